wino_f64_stream: RTL and testbench



---
 rtl/wino_f64_stream_if.sv | 27 ++
 rtl/wino_f64_stream.sv | 87 ++++++++
 tb/tb_wino_f64_stream.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wino_f64_stream_if.sv
// Tile-engine handshake bundle: coefficient load, input tile stream, output tile stream.
// The master side is the tile fetcher / writer pair; the slave side is the engine.
interface wino_f64_stream_if #(
  parameter int DW = 10,
  parameter int CW = 10,
  parameter int OW = 24
);
  logic            g_load;
  logic [4*CW-1:0] g_in;
  logic            g_ack;
  logic            in_valid;
  logic            in_ready;
  logic [9*DW-1:0] D;
  logic            out_valid;
  logic            out_ready;
  logic [6*OW-1:0] Z;

  modport master (
    output g_load, g_in, in_valid, D, out_ready,
    input  g_ack, in_ready, out_valid, Z
  );

  modport slave (
    input  g_load, g_in, in_valid, D, out_ready,
    output g_ack, in_ready, out_valid, Z
  );
endinterface

// File: rtl/wino_f64_stream.sv
// Streaming 1-D F(6,4) tile engine: 9-sample tiles correlated with a 4-tap loadable
// filter, accumulated over CH channel tiles into one 6-element output tile.
module wino_f64_stream #(
  parameter int DW = 10,
  parameter int CW = 10,
  parameter int CH = 4,
  parameter int OW = 24
) (
  input logic              clk,
  input logic              rst,
  wino_f64_stream_if.slave io
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic [CHW-1:0]  in_ch;
  logic [9*DW-1:0] tile_a;
  logic            first_a, last_a, valid_a;
  logic [CW-1:0]   g_r [4];
  logic [OW-1:0]   acc [6];
  logic [OW-1:0]   p   [6];
  logic [OW-1:0]   sum [6];
  logic [6*OW-1:0] z_r;
  logic            out_valid_r, g_ack_r;
  logic            ch_zero, ch_last, adv, accept, g_take;

  assign ch_zero = (in_ch == '0);
  assign ch_last = (in_ch == CHW'(CH - 1));
  // A last tile may only leave stage A when the output register is free or draining.
  assign adv     = valid_a && (!last_a || !out_valid_r || io.out_ready);
  assign io.in_ready = rst && (!valid_a || adv) && !(io.g_load && ch_zero);
  assign accept  = io.in_valid && io.in_ready;
  // g_ack_r guard keeps a still-held g_load from re-latching in the acknowledge cycle.
  assign g_take  = io.g_load && ch_zero && !valid_a && !g_ack_r;

  assign io.g_ack     = g_ack_r;
  assign io.out_valid = out_valid_r;
  assign io.Z         = z_r;

  // Direct MACs, all terms sign-extended to OW so the sums wrap modulo 2^OW.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      p[i] = '0;
      for (int k = 0; k < 4; k++)
        p[i] = p[i] + OW'($signed(tile_a[(8-i-k)*DW +: DW])) * OW'($signed(g_r[k]));
      sum[i] = first_a ? p[i] : acc[i] + p[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ch       <= '0;
      tile_a      <= '0;
      first_a     <= 1'b0;
      last_a      <= 1'b0;
      valid_a     <= 1'b0;
      z_r         <= '0;
      out_valid_r <= 1'b0;
      g_ack_r     <= 1'b0;
      for (int k = 0; k < 4; k++) g_r[k] <= '0;
      for (int i = 0; i < 6; i++) acc[i] <= '0;
    end else begin
      g_ack_r <= g_take;
      if (g_take)
        for (int k = 0; k < 4; k++) g_r[k] <= io.g_in[(3-k)*CW +: CW];

      if (accept) begin
        tile_a  <= io.D;
        first_a <= ch_zero;
        last_a  <= ch_last;
        valid_a <= 1'b1;
        in_ch   <= ch_last ? '0 : in_ch + 1'b1;
      end else if (adv) begin
        valid_a <= 1'b0;
      end

      if (adv)
        for (int i = 0; i < 6; i++) acc[i] <= sum[i];

      if (adv && last_a) begin
        for (int i = 0; i < 6; i++) z_r[(5-i)*OW +: OW] <= sum[i];
        out_valid_r <= 1'b1;
      end else if (out_valid_r && io.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wino_f64_stream.sv
// Bench for wino_f64_stream: one CH=1 and one CH=4 instance share the stimulus,
// a mux selects which one is observed; a correlation model scoreboards every output.
module tb_wino_f64_stream;
  localparam int DW = 10, CW = 10, OW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b0, sel4 = 1'b0;
  logic            g_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4*CW-1:0] g_in = '0;
  logic [9*DW-1:0] d_in = '0;
  logic            g_ack, in_ready, out_valid;
  logic [6*OW-1:0] z;

  wino_f64_stream_if #(.DW(DW), .CW(CW), .OW(OW)) bus1 ();
  wino_f64_stream_if #(.DW(DW), .CW(CW), .OW(OW)) bus4 ();

  assign bus1.g_load = g_load;   assign bus4.g_load = g_load;
  assign bus1.g_in = g_in;       assign bus4.g_in = g_in;
  assign bus1.in_valid = in_valid; assign bus4.in_valid = in_valid;
  assign bus1.D = d_in;          assign bus4.D = d_in;
  assign bus1.out_ready = out_ready; assign bus4.out_ready = out_ready;
  assign g_ack     = sel4 ? bus4.g_ack     : bus1.g_ack;
  assign in_ready  = sel4 ? bus4.in_ready  : bus1.in_ready;
  assign out_valid = sel4 ? bus4.out_valid : bus1.out_valid;
  assign z         = sel4 ? bus4.Z         : bus1.Z;

  wino_f64_stream #(.DW(DW), .CW(CW), .CH(1), .OW(OW)) dut1 (.clk(clk), .rst(rst), .io(bus1.slave));
  wino_f64_stream #(.DW(DW), .CW(CW), .CH(4), .OW(OW)) dut4 (.clk(clk), .rst(rst), .io(bus4.slave));

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [6*OW-1:0] act, input logic [6*OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*CW-1:0] pk_g(input int g0, input int g1, input int g2, input int g3);
    return {CW'(g0), CW'(g1), CW'(g2), CW'(g3)};
  endfunction
  function automatic logic [9*DW-1:0] pk_d(input int a [9]);
    logic [9*DW-1:0] r;
    for (int j = 0; j < 9; j++) r[(8-j)*DW +: DW] = DW'(a[j]);
    return r;
  endfunction
  function automatic logic [6*OW-1:0] pk_z(input int a [6]);
    logic [6*OW-1:0] r;
    for (int j = 0; j < 6; j++) r[(5-j)*OW +: OW] = OW'(a[j]);
    return r;
  endfunction
  function automatic logic [9*DW-1:0] dall(input int v);
    logic [9*DW-1:0] r;
    for (int j = 0; j < 9; j++) r[j*DW +: DW] = DW'(v);
    return r;
  endfunction
  function automatic logic [6*OW-1:0] zall(input int v);
    logic [6*OW-1:0] r;
    for (int j = 0; j < 6; j++) r[j*OW +: OW] = OW'(v);
    return r;
  endfunction

  // y_i contribution of one tile: sum over k of d[i+k]*g[k], plain integer arithmetic
  function automatic int corr(input logic [9*DW-1:0] d, input logic [4*CW-1:0] g, input int i);
    int s;
    logic signed [DW-1:0] dv;
    logic signed [CW-1:0] gv;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      dv = d[(8-i-k)*DW +: DW];
      gv = g[(3-k)*CW +: CW];
      s += int'(dv) * int'(gv);
    end
    return s;
  endfunction

  // Reference model and scoreboard
  int              m_ch = 0, n_out = 0;
  int              m_acc [6];
  logic [4*CW-1:0] g_cur = '0, g_grp = '0;
  logic [6*OW-1:0] exp_q [$];
  logic [6*OW-1:0] last_z = '0, prev_z = '0, e;
  logic            prev_stall = 1'b0, prev_sel = 1'b0;

  always @(negedge clk) begin
    if (prev_stall && sel4 == prev_sel) begin
      chk("hold_valid", {143'd0, out_valid}, {143'd0, 1'b1});
      chk("hold_z", z, prev_z);
    end
    prev_stall = rst && out_valid && !out_ready;
    prev_z = z;
    prev_sel = sel4;
    if (!rst) begin
      m_ch = 0;
      g_cur = '0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        last_z = z;
        if (exp_q.size() == 0) chk("unexpected_output", z, '0 ^ {6*OW{1'bx}});
        else begin
          e = exp_q.pop_front();
          chk("scoreboard_z", z, e);
        end
      end
      if (in_valid && in_ready) begin
        if (m_ch == 0) begin
          g_grp = g_cur;
          for (int i = 0; i < 6; i++) m_acc[i] = 0;
        end
        for (int i = 0; i < 6; i++) m_acc[i] += corr(d_in, g_grp, i);
        m_ch++;
        if (m_ch == (sel4 ? 4 : 1)) begin
          exp_q.push_back(pk_z(m_acc));
          m_ch = 0;
        end
      end
      if (g_ack) g_cur = g_in;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b0; sel4 = s; in_valid = 1'b0; g_load = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
  endtask

  // Wait for g_ack (c = cycles from now, -1 on timeout), then count further pulses.
  task automatic wait_ack(output int c, output int acks);
    c = -1; acks = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (g_ack) begin c = k; acks++; end
      tick();
      if (c >= 0) break;
    end
    g_load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (g_ack) acks++;
      tick();
    end
  endtask

  task automatic load_g(input logic [4*CW-1:0] g, output int acks);
    int c;
    g_in = g; g_load = 1'b1;
    wait_ack(c, acks);
  endtask

  task automatic send(input logic [9*DW-1:0] d, output int waits);
    bit done;
    in_valid = 1'b1; d_in = d; waits = 0; done = 0;
    while (!done && waits < 40) begin
      @(negedge clk); done = in_ready;
      tick();
      if (!done) waits++;
    end
    in_valid = 1'b0;
    if (!done) waits = -1;
  endtask

  task automatic wait_out(output int c, output logic [6*OW-1:0] zz);
    c = -1; zz = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin c = k; zz = z; end
      tick();
      if (c >= 0) break;
    end
  endtask

  function automatic logic [9*DW-1:0] rnd_tile();
    logic [9*DW-1:0] r;
    for (int j = 0; j < 9; j++)
      r[j*DW +: DW] = ($urandom_range(0, 7) == 0) ? {1'b1, {(DW-1){1'b0}}} : DW'($urandom);
    return r;
  endfunction
  function automatic logic [4*CW-1:0] rnd_g();
    logic [4*CW-1:0] r;
    for (int j = 0; j < 4; j++)
      r[j*CW +: CW] = ($urandom_range(0, 7) == 0) ? {1'b1, {(CW-1){1'b0}}} : CW'($urandom);
    return r;
  endfunction

  task automatic rand_run(input int n);
    bit took, acked;
    for (int c = 0; c < n + 300; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      acked = g_ack;
      tick();
      if (acked) g_load = 1'b0;
      if (c < n) begin
        if (took || !in_valid) begin
          in_valid = ($urandom_range(0, 3) != 0);
          d_in = rnd_tile();
        end
        out_ready = ($urandom_range(0, 3) != 0);
        if (!g_load && !acked && $urandom_range(0, 40) == 0) begin
          g_load = 1'b1;
          g_in = rnd_g();
        end
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() == 0 && !g_load) break;
      end
    end
    g_load = 1'b0;
    chk("drain_empty", 144'(exp_q.size()), '0);
  endtask

  typedef struct packed {
    logic [4*CW-1:0] g;
    logic [9*DW-1:0] d;
    logic [6*OW-1:0] z;
  } vec_t;

  vec_t vt [5];

  initial begin
    int da [9];
    int za [6];
    int acks, w, c, n0, acc_n;
    logic [6*OW-1:0] zz;
    logic [9*DW-1:0] bp_t [3];

    da = '{1, 2, 3, 4, 5, 6, 7, 8, 9};      za = '{30, 40, 50, 60, 70, 80};
    vt[0].g = pk_g(1, 2, 3, 4);             vt[0].d = pk_d(da); vt[0].z = pk_z(za);
    vt[1].g = pk_g(-1, 0, 0, 0);            vt[1].d = dall(-512); vt[1].z = zall(512);
    vt[2].g = pk_g(-512, -512, -512, -512); vt[2].d = dall(-512); vt[2].z = zall(1048576);
    da = '{3, -5, 7, 0, -1, 2, 9, -8, 4};   za = '{22, -10, 1, -13, 31, -31};
    vt[3].g = pk_g(1, -1, 2, -2);           vt[3].d = pk_d(da); vt[3].z = pk_z(za);
    vt[4].g = pk_g(511, 511, 511, 511);     vt[4].d = dall(-512); vt[4].z = zall(-1046528);

    // CH=1 reset state and table vectors
    do_reset(1'b0);
    @(negedge clk);
    chk("reset_out_valid", {143'd0, out_valid}, '0);
    chk("reset_z", z, '0);
    chk("reset_g_ack", {143'd0, g_ack}, '0);
    tick();
    for (int v = 0; v < 5; v++) begin
      load_g(vt[v].g, acks);
      chk($sformatf("vec%0d_g_ack_once", v), 144'(acks), 144'(1));
      send(vt[v].d, w);
      chk($sformatf("vec%0d_accept_wait", v), 144'(w), '0);
      wait_out(c, zz);
      chk($sformatf("vec%0d_latency", v), 144'(c), 144'(1));
      chk($sformatf("vec%0d_z", v), zz, vt[v].z);
    end

    // CH=1 backpressure: 3 tiles offered, output blocked for 5 cycles
    load_g(pk_g(1, 2, 3, 4), acks);
    da = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    bp_t[0] = pk_d(da); bp_t[1] = dall(1); bp_t[2] = dall(2);
    out_ready = 1'b0; in_valid = 1'b1; d_in = bp_t[0]; acc_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      tick();
      d_in = bp_t[(acc_n > 2) ? 2 : acc_n];
    end
    @(negedge clk);
    chk("bp_accepted", 144'(acc_n), 144'(2));
    chk("bp_in_ready", {143'd0, in_ready}, '0);
    chk("bp_held_z", z, vt[0].z);
    tick();
    n0 = n_out; out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc_n++;
      tick();
      if (acc_n >= 3) in_valid = 1'b0;
    end
    chk("bp_total_accepted", 144'(acc_n), 144'(3));
    chk("bp_outputs", 144'(n_out - n0), 144'(3));
    chk("bp_last_z", last_z, zall(20));

    // CH=4: one output per group of four
    do_reset(1'b1);
    load_g(pk_g(1, 0, 0, 0), acks);
    chk("ch4_g_ack_once", 144'(acks), 144'(1));
    n0 = n_out;
    for (int t = 1; t <= 3; t++) send(dall(t), w);
    repeat (3) begin
      @(negedge clk);
      chk("ch4_no_early_out", {143'd0, out_valid}, '0);
      tick();
    end
    send(dall(4), w);
    wait_out(c, zz);
    chk("ch4_latency", 144'(c), 144'(1));
    chk("ch4_z", zz, zall(10));
    repeat (4) tick();
    chk("ch4_one_output", 144'(n_out - n0), 144'(1));

    // CH=4: reset mid-group discards partial accumulation
    send(dall(5), w);
    send(dall(5), w);
    rst = 1'b0; in_valid = 1'b1; d_in = dall(7);
    @(negedge clk);
    chk("rst_in_ready_low", {143'd0, in_ready}, '0);
    tick();
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {143'd0, out_valid}, '0);
    chk("rst_in_ready_after", {143'd0, in_ready}, {143'd0, 1'b1});
    tick();
    load_g(pk_g(1, 0, 0, 0), acks);
    for (int t = 0; t < 3; t++) send(dall(1), w);
    send(dall(1), w);
    wait_out(c, zz);
    chk("rst_regroup_z", zz, zall(4));

    // CH=4: coefficient load requested mid-group
    repeat (2) tick();
    send(dall(1), w);
    send(dall(1), w);
    g_in = pk_g(2, 0, 0, 0); g_load = 1'b1;
    send(dall(1), w);
    chk("midload_tile3_wait", 144'(w), '0);
    send(dall(1), w);
    chk("midload_tile4_wait", 144'(w), '0);
    wait_ack(c, acks);
    chk("midload_ack_cycle", 144'(c), 144'(2));
    chk("midload_ack_once", 144'(acks), 144'(1));
    chk("midload_old_g_z", last_z, zall(4));
    for (int t = 0; t < 3; t++) send(dall(1), w);
    send(dall(1), w);
    wait_out(c, zz);
    chk("midload_new_g_z", zz, zall(8));

    // Randomized traffic against the model
    do_reset(1'b0);
    rand_run(800);
    do_reset(1'b1);
    rand_run(2500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
